// File: rtl/wseq_pkg.sv
// Shared definitions for the weights-RAM uCode sequencer: layer one-hot codes,
// uCode field layout, FSM state encoding and a uCode packing helper.
package wseq_pkg;

    // One-hot layer select codes (also the uCode Mode field value)
    localparam int          MODE_W     = 5;
    localparam logic [4:0]  CONV1D_1st = 5'b10000;
    localparam logic [4:0]  CONV1D_2nd = 5'b01000;
    localparam logic [4:0]  CONV1D_3rd = 5'b00100;
    localparam logic [4:0]  FC_1st     = 5'b00010;
    localparam logic [4:0]  FC_2nd     = 5'b00001;

    // uCode word layout: [14:11] Width, [10:6] Depth, [5:1] Mode, [0] Enable
    localparam int UC_W          = 15;
    localparam int UC_WIDTH_LSB  = 11;
    localparam int UC_WIDTH_BITS = 4;
    localparam int UC_DEPTH_LSB  = 6;
    localparam int UC_DEPTH_BITS = 5;
    localparam int UC_MODE_LSB   = 1;
    localparam int UC_EN_BIT     = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Build an enabled uCode word for one weight address
    function automatic logic [UC_W-1:0] ucode_pack(
        input logic [UC_WIDTH_BITS-1:0] width,
        input logic [UC_DEPTH_BITS-1:0] depth,
        input logic [MODE_W-1:0]        mode
    );
        logic [UC_W-1:0] word;
        word                                 = '0;
        word[UC_WIDTH_LSB +: UC_WIDTH_BITS]  = width;
        word[UC_DEPTH_LSB +: UC_DEPTH_BITS]  = depth;
        word[UC_MODE_LSB  +: MODE_W]         = mode;
        word[UC_EN_BIT]                      = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/wseq_addr_counter.sv
// Nested weight-address counter: Depth is the fast counter, Width the slow one.
// Limits are latched on load as (count-1); the sweep wraps back to (0,0) after
// the last address so back-to-back passes need no reload.
module wseq_addr_counter
    import wseq_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     en,
    input  logic [UC_DEPTH_BITS-1:0] depth_lim,
    input  logic [UC_WIDTH_BITS-1:0] width_lim,
    output logic [UC_DEPTH_BITS-1:0] depth_nxt,
    output logic [UC_WIDTH_BITS-1:0] width_nxt,
    output logic                     last
);

    logic [UC_DEPTH_BITS-1:0] depth_q, depth_d, dlim_q, dlim_d;
    logic [UC_WIDTH_BITS-1:0] width_q, width_d, wlim_q, wlim_d;

    // Next address in sweep order, the last-address flag, and load/advance muxing
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        depth_nxt = depth_q + 5'd1;
        width_nxt = width_q;
        if (depth_q == dlim_q) begin
            depth_nxt = '0;
            width_nxt = (width_q == wlim_q) ? '0 : width_q + 4'd1;
        end
        last = (depth_q == dlim_q) && (width_q == wlim_q);

        depth_d = depth_q;
        width_d = width_q;
        dlim_d  = dlim_q;
        wlim_d  = wlim_q;
        if (load) begin
            depth_d = '0;
            width_d = '0;
            dlim_d  = depth_lim;
            wlim_d  = width_lim;
        end else if (en) begin
            depth_d = depth_nxt;
            width_d = width_nxt;
        end
    end

    // Counter and limit registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
        if (!rst_n) begin
            depth_q <= '0;
            width_q <= '0;
            dlim_q  <= '0;
            wlim_q  <= '0;
        end else begin
            depth_q <= depth_d;
            width_q <= width_d;
            dlim_q  <= dlim_d;
            wlim_q  <= wlim_d;
        end
    end

endmodule

// File: rtl/weights_ucode_sequencer.sv
// Weights-RAM uCode initiator: on Start walks every (Width, Depth) address of
// the selected layer, one word per un-stalled cycle, with Rd_valid aligned to
// the RAM's 1-cycle registered read and a Done pulse in the drain cycle.
// Optional feature macro: WSEQ_REPEAT_EN adds Repeat[3:0] (sweep runs Repeat+1 times).
module weights_ucode_sequencer
    import wseq_pkg::*;
#(
    parameter int C1_DEPTH  = 16,
    parameter int C2_DEPTH  = 16,
    parameter int C2_WIDTH  = 8,
    parameter int C3_DEPTH  = 16,
    parameter int C3_WIDTH  = 8,
    parameter int FC1_DEPTH = 32,
    parameter int FC1_WIDTH = 16,
    parameter int FC2_WIDTH = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [MODE_W-1:0] Mode_sel,
`ifdef WSEQ_REPEAT_EN
    input  logic [3:0]        Repeat,
`endif
    input  logic              Stall,
    output logic [UC_W-1:0]   uCode,
    output logic              Rd_valid,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    state_e                   state_q, state_d;
    logic [UC_W-1:0]          ucode_q, ucode_d;
    logic [MODE_W-1:0]        mode_q, mode_d;
    logic [3:0]               rep_q, rep_d, rep_load;
    logic                     rd_valid_q, rd_valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic                     cnt_load, cnt_en, cnt_last;
    logic [UC_DEPTH_BITS-1:0] cnt_depth_nxt, lim_depth;
    logic [UC_WIDTH_BITS-1:0] cnt_width_nxt, lim_width;

`ifdef WSEQ_REPEAT_EN
    assign rep_load = Repeat;
`else
    assign rep_load = 4'd0;
`endif

    // Map the requested layer to its (count-1) limits; C1 has one Width, FC2 one Depth
    always_comb begin
        lim_depth = '0;
        lim_width = '0;
        case (Mode_sel)
            CONV1D_1st: begin lim_depth = 5'(C1_DEPTH - 1);  lim_width = '0;                    end
            CONV1D_2nd: begin lim_depth = 5'(C2_DEPTH - 1);  lim_width = 4'(C2_WIDTH - 1);  end
            CONV1D_3rd: begin lim_depth = 5'(C3_DEPTH - 1);  lim_width = 4'(C3_WIDTH - 1);  end
            FC_1st:     begin lim_depth = 5'(FC1_DEPTH - 1); lim_width = 4'(FC1_WIDTH - 1); end
            FC_2nd:     begin lim_depth = '0;                lim_width = 4'(FC2_WIDTH - 1); end
            default:    begin lim_depth = '0;                lim_width = '0;                end
        endcase
    end

    wseq_addr_counter u_addr_counter (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .load      (cnt_load),
        .en        (cnt_en),
        .depth_lim (lim_depth),
        .width_lim (lim_width),
        .depth_nxt (cnt_depth_nxt),
        .width_nxt (cnt_width_nxt),
        .last      (cnt_last)
    );

    // FSM next state, next uCode word and next registered strobes
    always_comb begin
        state_d    = state_q;
        ucode_d    = ucode_q;
        mode_d     = mode_q;
        rep_d      = rep_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        // The RAM returns data one cycle after an accepted (enabled, unstalled) word
        rd_valid_d = ucode_q[UC_EN_BIT] & ~Stall;

        case (state_q)
            ST_IDLE: begin
                ucode_d = '0;
                if (Start) begin
                    if ($onehot(Mode_sel)) begin
                        state_d  = ST_RUN;
                        mode_d   = Mode_sel;
                        rep_d    = rep_load;
                        cnt_load = 1'b1;
                        ucode_d  = ucode_pack('0, '0, Mode_sel);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (!Stall) begin
                    if (cnt_last && (rep_q == 4'd0)) begin
                        state_d = ST_DRAIN;
                        ucode_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        // Counter wraps to (0,0) after the last address, starting the next pass
                        cnt_en  = 1'b1;
                        ucode_d = ucode_pack(cnt_width_nxt, cnt_depth_nxt, mode_q);
                        if (cnt_last) begin
                            rep_d = rep_q - 4'd1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
                ucode_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                ucode_d = '0;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    // State and registered outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            ucode_q    <= '0;
            mode_q     <= '0;
            rep_q      <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ucode_q    <= ucode_d;
            mode_q     <= mode_d;
            rep_q      <= rep_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign uCode    = ucode_q;
    assign Rd_valid = rd_valid_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Err      = err_q;

endmodule

// File: tb/tb_weights_ucode_sequencer.sv
// Directed self-checking bench for weights_ucode_sequencer. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_weights_ucode_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [4:0]  Mode_sel;
    logic        Stall;
`ifdef WSEQ_REPEAT_EN
    logic [3:0]  Repeat;
`endif
    logic [14:0] uCode;
    logic        Rd_valid, Busy, Done, Err;

    int n_cmp  = 0;
    int n_fail = 0;

    weights_ucode_sequencer dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .Mode_sel (Mode_sel),
`ifdef WSEQ_REPEAT_EN
        .Repeat   (Repeat),
`endif
        .Stall    (Stall),
        .uCode    (uCode),
        .Rd_valid (Rd_valid),
        .Busy     (Busy),
        .Done     (Done),
        .Err      (Err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected uCode word for a given address: {Width, Depth, Mode, Enable}
    function automatic logic [14:0] exp_word(input int w, input int d, input logic [4:0] ms);
        logic [3:0] wv;
        logic [4:0] dv;
        wv = 4'(w);
        dv = 5'(d);
        return {wv, dv, ms, 1'b1};
    endfunction

    task automatic idle_check(input string tag);
        check({tag, ".ucode"}, 32'(uCode), 32'h0);
        check({tag, ".busy"},  32'(Busy),  32'h0);
        check({tag, ".done"},  32'(Done),  32'h0);
        check({tag, ".rdv"},   32'(Rd_valid), 32'h0);
    endtask

    // Run one layer from Start to the idle cycle after Done, checking every cycle.
    // stall_beat/stall_len hold Stall high while that beat is presented;
    // start_beat pulses a (to be ignored) Start while that beat is presented.
    task automatic run_layer(input string tag, input logic [4:0] ms, input int nd, input int nw,
                             input int stall_beat, input int stall_len, input int start_beat,
                             input int reps, input logic [14:0] first_exp, input logic [14:0] last_exp);
        int   total, beat, stall_left, cyc, n_valid, n_done;
        bit   acc_prev;
        logic [14:0] first_seen, last_seen;
        total      = nd * nw * (reps + 1);
        beat       = 0;
        stall_left = stall_len;
        cyc        = 0;
        n_valid    = 0;
        n_done     = 0;
        acc_prev   = 1'b0;
        first_seen = '0;
        last_seen  = '0;
        Mode_sel = ms;
`ifdef WSEQ_REPEAT_EN
        Repeat = 4'(reps);
`endif
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        while (beat < total && cyc < 4000) begin
            if (cyc == 0) first_seen = uCode;
            last_seen = uCode;
            check({tag, ".ucode"}, 32'(uCode), 32'(exp_word((beat / nd) % nw, beat % nd, ms)));
            check({tag, ".busy"},  32'(Busy), 32'h1);
            check({tag, ".done"},  32'(Done), 32'h0);
            check({tag, ".err"},   32'(Err),  32'h0);
            check({tag, ".rdv"},   32'(Rd_valid), 32'(acc_prev));
            n_valid += int'(Rd_valid);
            Start    = (beat == start_beat) && (stall_left == stall_len);
            Mode_sel = Start ? 5'b00001 : ms;
            if (beat == stall_beat && stall_left > 0) begin
                Stall = 1'b1;
                stall_left--;
                acc_prev = 1'b0;
            end else begin
                Stall = 1'b0;
                acc_prev = 1'b1;
                beat++;
            end
            @(negedge Clk);
            cyc++;
        end
        Stall    = 1'b0;
        Start    = 1'b0;
        Mode_sel = ms;
        check({tag, ".cycles"}, 32'(cyc), 32'(total + stall_len));
        check({tag, ".first"},  32'(first_seen), 32'(first_exp));
        check({tag, ".last"},   32'(last_seen),  32'(last_exp));
        // Drain cycle: final data beat valid, Done pulses, no longer busy
        check({tag, ".drain.ucode"}, 32'(uCode), 32'h0);
        check({tag, ".drain.rdv"},   32'(Rd_valid), 32'h1);
        check({tag, ".drain.done"},  32'(Done), 32'h1);
        check({tag, ".drain.busy"},  32'(Busy), 32'h0);
        n_valid += int'(Rd_valid);
        n_done  += int'(Done);
        @(negedge Clk);
        idle_check({tag, ".idle"});
        n_done += int'(Done);
        check({tag, ".n_valid"}, 32'(n_valid), 32'(total));
        check({tag, ".n_done"},  32'(n_done),  32'h1);
    endtask

    initial begin
        Reset_n  = 1'b0;
        Start    = 1'b0;
        Mode_sel = 5'b0;
        Stall    = 1'b0;
`ifdef WSEQ_REPEAT_EN
        Repeat   = 4'd0;
`endif
        repeat (2) @(negedge Clk);
        idle_check("reset");
        check("reset.err", 32'(Err), 32'h0);
        Reset_n = 1'b1;
        @(negedge Clk);
        idle_check("post_reset");

        // C2, no stall: 0x0011 first, 0x3BD1 last, 128 beats
        run_layer("c2", 5'b01000, 16, 8, -1, 0, -1, 0, 15'h0011, 15'h3BD1);

        // FC2: Depth fixed at 0, Width steps
        run_layer("fc2", 5'b00001, 1, 16, -1, 0, -1, 0, 15'h0003, 15'h7803);

        // C2 with a 3-cycle stall at beat 10 and a Start pulse mid-run
        run_layer("c2_stall", 5'b01000, 16, 8, 10, 3, 40, 0, 15'h0011, 15'h3BD1);

        // FC1: largest sweep, 32 x 16
        run_layer("fc1", 5'b00010, 32, 16, 100, 1, -1, 0, 15'h0005, 15'h7FC5);

        // Illegal one-hot codes: Err pulse, nothing starts
        Mode_sel = 5'b00110;
        Start    = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check("illegal.err", 32'(Err), 32'h1);
        idle_check("illegal");
        @(negedge Clk);
        check("illegal.err_clear", 32'(Err), 32'h0);
        check("illegal.busy2", 32'(Busy), 32'h0);
        Mode_sel = 5'b00000;
        Start    = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check("zero.err", 32'(Err), 32'h1);
        check("zero.busy", 32'(Busy), 32'h0);
        @(negedge Clk);

        // Reset mid-C1 at beat 5: outputs clear at once, no Done follows
        Mode_sel = 5'b10000;
        Start    = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (5) @(negedge Clk);
        check("c1_abort.beat5", 32'(uCode), 32'(15'h0161));
        check("c1_abort.busy",  32'(Busy), 32'h1);
        #2 Reset_n = 1'b0;
        #1;
        idle_check("c1_abort.async");
        @(negedge Clk);
        idle_check("c1_abort.held");
        Reset_n = 1'b1;
        repeat (2) begin
            @(negedge Clk);
            idle_check("c1_abort.after");
        end

        // Fresh C1 after the abort completes all 16 beats
        run_layer("c1", 5'b10000, 16, 1, -1, 0, -1, 0, 15'h0021, 15'h03E1);

`ifdef WSEQ_REPEAT_EN
        // Three back-to-back passes of C1, one Done at the end
        run_layer("c1_rep", 5'b10000, 16, 1, -1, 0, -1, 2, 15'h0021, 15'h03E1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
